// File: rtl/parity_frame_generator.sv
// Streaming per-word parity generator that closes every frame with a
// longitudinal-parity (LRC) trailer word on a valid/ready output stream.
module parity_frame_generator #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   out_data,
    output logic              out_last,
    output logic              out_is_lrc,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        TRAILER = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] lrc;
    logic              mode;

    logic              slot_free;
    logic              accept;
    logic              beat_mode;
    logic              load_trailer;
    logic [DATA_W-1:0] trailer_word;

    // The output register can take a new word when it is empty or being drained.
    assign slot_free    = !out_valid || out_ready;
    assign in_ready     = rst_n && (state != TRAILER) && slot_free;
    assign accept       = in_valid && in_ready;
    // The first beat of a frame uses odd_sel directly; later beats use the latched mode.
    assign beat_mode    = (state == IDLE) ? odd_sel : mode;
    assign load_trailer = (state == TRAILER) && slot_free;
    assign trailer_word = lrc ^ {DATA_W{mode}};
    assign busy         = (state != IDLE);

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lrc        <= '0;
            mode       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_is_lrc <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode  <= odd_sel;
                        state <= in_last ? TRAILER : STREAM;
                    end
                end
                STREAM: begin
                    if (accept && in_last) begin
                        state <= TRAILER;
                    end
                end
                TRAILER: begin
                    if (slot_free) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                out_data   <= {(^in_data) ^ beat_mode, in_data};
                out_valid  <= 1'b1;
                out_last   <= 1'b0;
                out_is_lrc <= 1'b0;
                lrc        <= lrc ^ in_data;
            end else if (load_trailer) begin
                out_data   <= {(^trailer_word) ^ mode, trailer_word};
                out_valid  <= 1'b1;
                out_last   <= 1'b1;
                out_is_lrc <= 1'b1;
                lrc        <= '0;
                frame_cnt  <= frame_cnt + CNT_W'(1);
            end else if (out_ready) begin
                // Payload fields hold their last value once the word is consumed.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_generator.sv
// Self-checking bench: frames are expanded by a queue-based reference model
// into the expected output word stream, then compared beat by beat.
module tb_parity_frame_generator;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              odd;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              odd_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W:0]   out_data;
    logic              out_last;
    logic              out_is_lrc;
    logic [CNT_W-1:0]  frame_cnt;
    logic              busy;

    parity_frame_generator #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .odd_sel    (odd_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_is_lrc (out_is_lrc),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t             in_q[$];
    logic [6:0]        exp_q[$];   // {is_lrc, last, parity, word}
    logic [DATA_W-1:0] fw[$];

    int         valid_pct  = 100;
    int         ready_mode = 0;    // 0 always, 1 random, 2 scripted, 3 never
    logic [0:15] script;
    int         sidx;
    int         ready_low;
    int         trailers;
    logic [DATA_W:0] last_trailer;
    logic       prev_stall;
    logic [7:0] prev_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic add_word(input logic [DATA_W-1:0] w);
        fw.push_back(w);
    endtask

    // Reference model: each word gets parity of its ones count plus mode; the
    // trailer bit per column is the column's ones count plus mode, mod 2.
    task automatic end_frame(input logic mode, input bit toggle);
        int col[DATA_W];
        int p;
        logic [DATA_W-1:0] t;
        beat_t b;
        foreach (col[k]) col[k] = 0;
        for (int i = 0; i < fw.size(); i++) begin
            b.data = fw[i];
            b.last = (i == fw.size() - 1);
            b.odd  = (i == 0) ? mode : (toggle ? ~mode : 1'($urandom_range(1)));
            in_q.push_back(b);
            p = ($countones(fw[i]) + int'(mode)) % 2;
            exp_q.push_back({2'b00, 1'(p), fw[i]});
            for (int k = 0; k < DATA_W; k++) col[k] += int'(fw[i][k]);
        end
        for (int k = 0; k < DATA_W; k++) t[k] = 1'((col[k] + int'(mode)) % 2);
        p = ($countones(t) + int'(mode)) % 2;
        exp_q.push_back({2'b11, 1'(p), t});
        fw.delete();
    endtask

    task automatic drive(input bit acc);
        beat_t b;
        if (acc) void'(in_q.pop_front());
        if (!(in_valid && !acc)) begin
            if (in_q.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
                b        = in_q[0];
                in_valid = 1'b1;
                in_data  = b.data;
                in_last  = b.last;
                odd_sel  = b.odd;
            end else begin
                in_valid = 1'b0;
                in_data  = 4'($urandom);
                in_last  = 1'($urandom_range(1));
                odd_sel  = 1'($urandom_range(1));
            end
        end
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(99) < 70);
            2:       out_ready = (sidx < 16) ? script[sidx] : 1'b1;
            default: out_ready = 1'b0;
        endcase
        sidx++;
    endtask

    // One clock: observe at the falling edge, then drive just after the rising edge.
    task automatic cycle();
        bit acc;
        logic [6:0] e;
        @(negedge clk);
        if (prev_stall)
            check("stable", 32'({out_valid, out_data, out_last, out_is_lrc}), 32'(prev_out));
        if (out_valid && !out_ready)
            check("stall_rdy", 32'(in_ready), 0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_out", 32'({out_is_lrc, out_last, out_data}), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check(e[6] ? "trailer" : "word", 32'({out_is_lrc, out_last, out_data}), 32'(e));
                if (e[6]) begin
                    trailers++;
                    check("frame_cnt", 32'(frame_cnt), trailers % 4);
                    last_trailer = out_data;
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_valid, out_data, out_last, out_is_lrc};
        if (!in_ready) ready_low++;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        drive(acc);
    endtask

    task automatic run(input int budget);
        int n = 0;
        ready_low = 0;
        sidx      = 0;
        drive(1'b0);
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) begin
            check("timeout", 32'(exp_q.size() + in_q.size()), 0);
            in_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic check_reset_vals();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_out_is_lrc", 32'(out_is_lrc), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 0);
    endtask

    // Reset lands between clock edges so the outputs must clear with no edge.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        in_q.delete();
        exp_q.delete();
        in_valid   = 1'b0;
        prev_stall = 1'b0;
        trailers   = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        odd_sel    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        trailers   = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        script     = 16'b1100_0011_1000_1111;
        #2;
        check_reset_vals();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Even mode, basic frame
        ready_mode = 0; valid_pct = 100;
        add_word(4'h1); add_word(4'h3); add_word(4'h7); end_frame(1'b0, 1'b0);
        run(50);
        check("t1_lrc", 32'(last_trailer), 32'h05);
        check("t1_cnt", 32'(frame_cnt), 1);
        check("t1_bubble", ready_low, 1);

        // Odd mode, same frame
        add_word(4'h1); add_word(4'h3); add_word(4'h7); end_frame(1'b1, 1'b0);
        run(50);
        check("t2_lrc", 32'(last_trailer), 32'h1A);
        check("t2_bubble", ready_low, 1);

        // Single-word frame
        add_word(4'hF); end_frame(1'b0, 1'b0);
        run(50);
        check("t3_lrc", 32'(last_trailer), 32'h0F);
        check("t3_bubble", ready_low, 1);

        // Mode latch with toggled odd_sel and scripted backpressure
        ready_mode = 2;
        for (int i = 0; i < 5; i++) add_word(4'($urandom));
        end_frame(1'b1, 1'b1);
        run(100);

        // Randomised traffic
        ready_mode = 1; valid_pct = 70;
        for (int f = 0; f < 60; f++) begin
            int len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) add_word(4'($urandom));
            end_frame(1'($urandom_range(1)), 1'b0);
        end
        run(20000);

        // Reset mid-stream
        ready_mode = 0; valid_pct = 100;
        add_word(4'h3); add_word(4'h4); add_word(4'h5); add_word(4'h6); end_frame(1'b0, 1'b0);
        drive(1'b0);
        cycle();
        cycle();
        check("busy_stream", 32'(busy), 1);
        async_reset();
        add_word(4'h2); end_frame(1'b0, 1'b0);
        run(50);
        check("t5a_lrc", 32'(last_trailer), 32'h12);
        check("t5a_cnt", 32'(frame_cnt), 1);

        // Reset while stalled in the trailer state
        ready_mode = 3;
        add_word(4'h5); end_frame(1'b1, 1'b0);
        drive(1'b0);
        cycle(); cycle(); cycle();
        check("trl_busy", 32'(busy), 1);
        check("trl_in_ready", 32'(in_ready), 0);
        check("trl_out_valid", 32'(out_valid), 1);
        async_reset();
        ready_mode = 0;
        add_word(4'h2); end_frame(1'b0, 1'b0);
        run(50);
        check("t5b_lrc", 32'(last_trailer), 32'h12);
        check("t5b_cnt", 32'(frame_cnt), 1);

        // Counter wrap across back-to-back single-word frames
        async_reset();
        for (int f = 0; f < 5; f++) begin
            add_word(4'($urandom));
            end_frame(1'($urandom_range(1)), 1'b0);
        end
        run(100);
        check("t6_bubbles", ready_low, 5);
        check("t6_cnt", 32'(frame_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
